// File: rtl/mux8_1_using2_1mux.sv
// mux8_1_using2_1mux: registered 8:1 bit selector built from a 3-level tree
// of seven 2:1 mux cells.
//
// Build option (macro MUX8_1_STAGE_REG_EN):
//   undefined : tree is fully combinational into one output register,
//               latency 1 cycle.
//   defined   : a register follows level 1 (4 bits) and level 2 (2 bits),
//               plus the output register after level 3; latency 3 cycles,
//               one result per cycle.
//
// Handshake: in_valid qualifies s/in on a clk edge; out_valid is in_valid
// delayed by the build latency and marks out as carrying that cycle's
// result. There is no back-pressure. out is loaded every cycle whatever
// in_valid is. Reset is synchronous and active-low; it clears every
// register, so a result that is in flight when reset is applied is dropped.

// Single 2:1 cell: y = sel ? b : a, purely combinational.
module mux8_1_mux2_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_sel,
  output logic o_y
);
  assign o_y = i_sel ? i_b : i_a;
endmodule

module mux8_1_using2_1mux (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] s,
  input  logic [7:0] in,
  input  logic       in_valid,
  output logic       out,
  output logic       out_valid
);

  // Level-1 outputs. Each cell chooses between an even/odd pair on s[0].
  logic [3:0] w_l1;

  mux8_1_mux2_cell u_l1_0 (.i_a(in[0]), .i_b(in[1]), .i_sel(s[0]), .o_y(w_l1[0]));
  mux8_1_mux2_cell u_l1_1 (.i_a(in[2]), .i_b(in[3]), .i_sel(s[0]), .o_y(w_l1[1]));
  mux8_1_mux2_cell u_l1_2 (.i_a(in[4]), .i_b(in[5]), .i_sel(s[0]), .o_y(w_l1[2]));
  mux8_1_mux2_cell u_l1_3 (.i_a(in[6]), .i_b(in[7]), .i_sel(s[0]), .o_y(w_l1[3]));

`ifdef MUX8_1_STAGE_REG_EN

  // Stage-1 registers: level-1 results plus the select bits still needed.
  logic [3:0] r_l1;
  logic [1:0] r_s1;
  logic       r_v1;
  // Stage-2 registers: level-2 results plus the last select bit.
  logic [1:0] r_l2;
  logic       r_s2;
  logic       r_v2;

  logic [1:0] w_l2;
  logic       w_l3;

  mux8_1_mux2_cell u_l2_0 (.i_a(r_l1[0]), .i_b(r_l1[1]), .i_sel(r_s1[0]), .o_y(w_l2[0]));
  mux8_1_mux2_cell u_l2_1 (.i_a(r_l1[2]), .i_b(r_l1[3]), .i_sel(r_s1[0]), .o_y(w_l2[1]));
  mux8_1_mux2_cell u_l3_0 (.i_a(r_l2[0]), .i_b(r_l2[1]), .i_sel(r_s2),    .o_y(w_l3));

  // Advance data, selects and valid one stage per edge; reset clears all.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_l1      <= 4'b0000;
      r_s1      <= 2'b00;
      r_v1      <= 1'b0;
      r_l2      <= 2'b00;
      r_s2      <= 1'b0;
      r_v2      <= 1'b0;
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      r_l1      <= w_l1;
      r_s1      <= s[2:1];
      r_v1      <= in_valid;
      r_l2      <= w_l2;
      r_s2      <= r_s1[1];
      r_v2      <= r_v1;
      out       <= w_l3;
      out_valid <= r_v2;
    end
  end

`else

  logic [1:0] w_l2;
  logic       w_l3;

  mux8_1_mux2_cell u_l2_0 (.i_a(w_l1[0]), .i_b(w_l1[1]), .i_sel(s[1]), .o_y(w_l2[0]));
  mux8_1_mux2_cell u_l2_1 (.i_a(w_l1[2]), .i_b(w_l1[3]), .i_sel(s[1]), .o_y(w_l2[1]));
  mux8_1_mux2_cell u_l3_0 (.i_a(w_l2[0]), .i_b(w_l2[1]), .i_sel(s[2]), .o_y(w_l3));

  // Capture the tree result and in_valid every edge; reset clears both.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out       <= w_l3;
      out_valid <= in_valid;
    end
  end

`endif

endmodule

// File: tb/tb_mux8_1_using2_1mux.sv
// Testbench for mux8_1_using2_1mux. Reference: out = bit s of in, delayed
// by the build latency, with reset flushing everything to zero.
module tb_mux8_1_using2_1mux;

`ifdef MUX8_1_STAGE_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] s = 3'd0;
  logic [7:0] in = 8'h00;
  logic       in_valid = 1'b0;
  logic       out;
  logic       out_valid;

  always #5 clk = ~clk;

  mux8_1_using2_1mux dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s        (s),
    .in       (in),
    .in_valid (in_valid),
    .out      (out),
    .out_valid(out_valid)
  );

  // ---------------- scoreboard ----------------
  // Each entry is {valid, data} expected at the output.
  logic [1:0] exp_q[$];
  logic [1:0] last_exp;
  bit         have_last = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got valid/out=%b required %b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic ref_sel(input logic [7:0] d, input logic [2:0] idx);
    int k;
    k = idx;
    return ((d >> k) & 8'h01) != 0;
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: apply inputs mid-cycle (output must not move), let the
  // edge sample them, then compare the output against the model.
  task automatic step(input string tag, input logic rn, input logic [2:0] sv,
                      input logic [7:0] iv, input logic vv);
    rst_n    = rn;
    s        = sv;
    in       = iv;
    in_valid = vv;
    #1;
    if (have_last) check({tag, "_hold"}, {out_valid, out}, last_exp);
    @(posedge clk);
    if (!rn) begin
      // Everything in flight is discarded; every stage now holds zero.
      exp_q.delete();
      for (int i = 0; i < LAT; i++) exp_q.push_back(2'b00);
    end else begin
      exp_q.push_back({vv, ref_sel(iv, sv)});
    end
    #1;
    if (exp_q.size() >= LAT) begin
      last_exp  = exp_q.pop_front();
      have_last = 1;
      check(tag, {out_valid, out}, last_exp);
    end
  endtask

  // Drain the pipeline with idle cycles so all pushed results get checked.
  task automatic flush(input string tag);
    for (int i = 0; i < LAT; i++) step(tag, 1'b1, 3'd0, 8'h00, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d;
    // Reset state
    step("reset", 1'b0, 3'd0, 8'h00, 1'b0);
    step("reset", 1'b0, 3'd5, 8'hFF, 1'b1);

    // Sweep s over 0..7 with alternating pattern
    for (int k = 0; k < 8; k++) step("sweep", 1'b1, 3'(k), 8'b10101010, 1'b1);
    flush("sweep_flush");

    // Walking one against every select value
    for (int k = 0; k < 8; k++) begin
      d = 8'b00000001 << k;
      for (int j = 0; j < 8; j++) step("walk1", 1'b1, 3'(j), d, 1'b1);
    end
    flush("walk1_flush");

    // Reset discards an in-flight result, capture resumes afterwards
    step("rst_pre", 1'b1, 3'd3, 8'hFF, 1'b1);
    step("rst_hold", 1'b0, 3'd3, 8'hFF, 1'b1);
    step("rst_hold", 1'b0, 3'd3, 8'hFF, 1'b1);
    for (int k = 0; k < LAT + 1; k++) step("rst_post", 1'b1, 3'd3, 8'hFF, 1'b1);
    flush("rst_flush");

    // Valid gating 1,0,1 with the selected bit high each cycle
    step("vgate", 1'b1, 3'd1, 8'h5A, 1'b1);
    step("vgate", 1'b1, 3'd1, 8'h5A, 1'b0);
    step("vgate", 1'b1, 3'd1, 8'h5A, 1'b1);
    flush("vgate_flush");

    // Back-to-back select changes, no bubbles
    step("b2b", 1'b1, 3'd7, 8'b10000001, 1'b1);
    step("b2b", 1'b1, 3'd0, 8'b10000001, 1'b1);
    step("b2b", 1'b1, 3'd6, 8'b10000001, 1'b1);
    step("b2b", 1'b1, 3'd1, 8'b10000001, 1'b1);
    flush("b2b_flush");

    // Exhaustive in x s, randomized valid
    for (int v = 0; v < 256; v++)
      for (int j = 0; j < 8; j++)
        step("exh", 1'b1, 3'(j), 8'(v), 1'($urandom_range(1, 0)));
    flush("exh_flush");

    // Random traffic with occasional reset
    for (int k = 0; k < 300; k++)
      step("rand", ($urandom_range(31, 0) != 0), 3'($urandom_range(7, 0)),
           8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
    flush("rand_flush");

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux8_1_using2_1mux.md
MUX8_1_USING2_1MUX -- requirements
Module: mux8_1_using2_1mux

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Port clk: input, 1 bit, rising-edge clock for all state.
REQ-003 Port rst_n: input, 1 bit, synchronous active-low reset, sampled on the clk rising edge.
REQ-004 Port s: input, 3 bits, select index 0..7.
REQ-005 Port in: input, 8 bits, data inputs; in[k] is the candidate for s==k.
REQ-006 Port in_valid: input, 1 bit, qualifies s/in for capture this cycle.
REQ-007 Port out: output, 1 bit, registered selected data bit.
REQ-008 Port out_valid: output, 1 bit, high when out carries a result for a captured in_valid cycle.

Function
REQ-009 Selection SHALL be out = in[s], with s interpreted as an unsigned binary index.
REQ-010 Selection SHALL be built only from 2:1 mux cells, 7 instances, arranged as a 3-level tree.
REQ-011 Level 1 SHALL use 4 cells on pairs (in[0],in[1]), (in[2],in[3]), (in[4],in[5]), (in[6],in[7]), each selected by s[0] (s[0]=0 picks the even bit).
REQ-012 Level 2 SHALL use 2 cells on the level-1 results, selected by s[1].
REQ-013 Level 3 SHALL use 1 cell, selected by s[2].
REQ-014 Each 2:1 cell SHALL be purely combinational: y = sel ? b : a.
REQ-015 Default build: out and out_valid SHALL be registered with a latency of 1 cycle from the clk edge that samples s/in/in_valid.
REQ-016 On every clk edge out SHALL load the tree result, whether or not in_valid is high.
REQ-017 out_valid SHALL load in_valid on every clk edge.
REQ-018 A change in s or in SHALL NOT cause a combinational change of out or out_valid between clock edges.
REQ-019 The selection SHALL be exhaustive with no X propagation: every s value 0..7 maps to exactly one input bit.

Reset
REQ-020 When rst_n=0 at a rising clk edge, out SHALL become 0 and out_valid SHALL become 0, overriding all inputs.
REQ-021 When rst_n=0, every internal pipeline register SHALL also clear to 0.
REQ-022 A result that is in flight when reset is asserted SHALL be discarded and SHALL NOT appear after reset is released.
REQ-023 On the first edge with rst_n=1, normal capture SHALL resume, so the first valid result follows 1 cycle later (default build) or 3 cycles later (pipelined build).

Configuration
REQ-024 Macro MUX8_1_STAGE_REG_EN SHALL select the pipelined build when defined.
REQ-025 With MUX8_1_STAGE_REG_EN defined:
- a register SHALL sit after level 1 (4 bits) and after level 2 (2 bits), and the output register after level 3;
- the select bits still needed downstream (s[2:1] after stage 1, s[2] after stage 2) and in_valid SHALL be delayed alongside the data;
- latency SHALL be 3 cycles;
- throughput SHALL be one result per cycle.
REQ-026 Without the macro, the tree SHALL be fully combinational into the single output register, with latency 1 (REQ-015).

Verification
REQ-027 Sweep: in=8'b10101010, in_valid=1, s stepped 0..7 one value per cycle -> out sequence 0,1,0,1,0,1,0,1 with out_valid=1, each result 1 cycle after its s (3 cycles in the pipelined build).
REQ-028 Walking one: in=8'b00000001<<k for k=0..7, s=k -> out=1; the same in with any s!=k -> out=0.
REQ-029 Reset: drive in=8'hFF, s=3, in_valid=1, then hold rst_n=0 for 2 edges -> out=0 and out_valid=0; after release, out=1 and out_valid=1 at the expected latency.
REQ-030 Valid gating: in=8'h5A, s=1, in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 at the latency; out=1 on all three cycles.
REQ-031 Back-to-back in the pipelined build: s changes every cycle 7,0,6,1 with in=8'b10000001 -> out 1,1,0,0, one per cycle with no bubbles.
REQ-032 Exhaustive: all 2048 combinations of in and s against the reference model out=in[s], in both builds, with zero mismatches.
